hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage RV32 core. Consumes decoded control (RegWrite*, MdOpE, LoadE)
//  and register indices from D/E/M/W, and drives forwarding selects, stall/flush enables and a multi-cycle M-unit start/done handshake.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hazard_ctrl_if.sv | 29 ++
 rtl/hazard_ctrl_md_seq.sv | 74 +++++++
 rtl/hazard_ctrl.sv | 69 ++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the RV32 pipeline hazard controller.
// Optional build macro: HAZARD_PERF_EN (enables the stall/flush perf counters).
package hazard_pkg;

    localparam int         REG_AW = 5;
    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // M-stage producer has priority over W; x0 is hard-wired zero and never forwarded.
    function automatic fwd_sel_e fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] rd_w,
                                         input logic              we_w);
        if (we_m && (rd_m != REG_X0) && (rd_m == rs))      return FWD_M;
        else if (we_w && (rd_w != REG_X0) && (rd_w == rs)) return FWD_W;
        else                                               return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: decoded indices/controls in, enables/selects out.
// Optional build macro: HAZARD_PERF_EN (perf counter ports carry live counts when defined).
interface hazard_if #(parameter int REG_AW = 5);
    logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E;
    logic [REG_AW-1:0] RdE, RdM, RdW;
    logic              RegWriteM, RegWriteW;
    logic              LoadE, PCSrcE, MdOpE, MdDone;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, StallE;
    logic              FlushD, FlushE, FlushM;
    logic              MdStart, MdTimeout;
    logic [31:0]       PerfStallCnt, PerfFlushCnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
               RegWriteM, RegWriteW, LoadE, PCSrcE, MdOpE, MdDone,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MdStart, MdTimeout,
               PerfStallCnt, PerfFlushCnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
               RegWriteM, RegWriteW, LoadE, PCSrcE, MdOpE, MdDone,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MdStart, MdTimeout,
               PerfStallCnt, PerfFlushCnt
    );
endinterface

// File: rtl/hazard_ctrl_md_seq.sv
// Multi-cycle mul/div sequencer: start pulse, E-hold stall and a sticky watchdog timeout.
// Optional build macro: HAZARD_PERF_EN (not used in this file).
module md_seq
    import hazard_pkg::*;
#(
    parameter int MD_MAX_CYCLES = 34
) (
    input  logic clk,
    input  logic reset,
    input  logic MdOpE,
    input  logic MdDone,
    output logic MdStart,
    output logic mdStall,
    output logic MdTimeout
);
    localparam int         CW     = $clog2(MD_MAX_CYCLES + 1);
    localparam logic [0:0] S_IDLE = MD_IDLE;
    localparam logic [0:0] S_BUSY = MD_BUSY;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          start, stall;

    always_comb begin
        // NOTE: every variable gets a default up front so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        start     = 1'b0;
        stall     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MdOpE) begin
                    start   = 1'b1;
                    stall   = 1'b1;
                    state_d = S_BUSY;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                if (MdDone) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(MD_MAX_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // While reset is held no new launch may leak out even if MdOpE is still high.
    assign MdStart   = start & ~reset;
    assign mdStall   = stall & ~reset;
    assign MdTimeout = timeout_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller top: forwarding, load-use stall, branch flush, M-unit stall and perf counters.
// Optional build macro: HAZARD_PERF_EN (saturating stall/flush counters; tied to zero otherwise).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_MAX_CYCLES = 34
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hz
);
    logic lw_stall, md_stall, flush_ctrl;

    assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);

    assign lw_stall   = hz.LoadE && (hz.RdE != REG_X0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    assign flush_ctrl = hz.PCSrcE;

    md_seq #(.MD_MAX_CYCLES(MD_MAX_CYCLES)) u_md_seq (
        .clk       (clk),
        .reset     (reset),
        .MdOpE     (hz.MdOpE),
        .MdDone    (hz.MdDone),
        .MdStart   (hz.MdStart),
        .mdStall   (md_stall),
        .MdTimeout (hz.MdTimeout)
    );

    // A taken branch kills the load-use bubble; an M-unit hold freezes E, so its load-use flush is suppressed.
    assign hz.StallF = md_stall | (lw_stall & ~flush_ctrl);
    assign hz.StallD = md_stall | (lw_stall & ~flush_ctrl);
    assign hz.StallE = md_stall;
    assign hz.FlushD = flush_ctrl;
    assign hz.FlushE = flush_ctrl | (lw_stall & ~md_stall);
    assign hz.FlushM = md_stall;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.StallF && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if ((hz.FlushD | hz.FlushE | hz.FlushM) && (flush_cnt_q != 32'hFFFF_FFFF))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.PerfStallCnt = stall_cnt_q;
    assign hz.PerfFlushCnt = flush_cnt_q;
`else
    assign hz.PerfStallCnt = 32'h0;
    assign hz.PerfFlushCnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; perf expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_if #(.REG_AW(5)) hif ();

    hazard_ctrl #(.MD_MAX_CYCLES(34)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
    function automatic logic [31:0] ctl();
        return {26'd0, hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE, hif.FlushM};
    endfunction

    function automatic logic [31:0] all_outs();
        return {18'd0, hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.StallE,
                hif.FlushD, hif.FlushE, hif.FlushM, hif.MdStart, hif.MdTimeout};
    endfunction

    task automatic clear_in();
        hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0;
        hif.RdE  = '0; hif.RdM  = '0; hif.RdW  = '0;
        hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
        hif.LoadE = 1'b0; hif.PCSrcE = 1'b0; hif.MdOpE = 1'b0; hif.MdDone = 1'b0;
    endtask

    // Advance one clock and leave time just after the edge for new stimulus.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [31:0] exp_perf;

    initial begin
        reset = 1'b1;
        clear_in();
        #12;
        check("reset_held_outs", all_outs(), 32'd0);
        reset = 1'b0;
        settle();
        check("reset_outs", all_outs(), 32'd0);
        check("reset_perf_stall", hif.PerfStallCnt, 32'd0);
        check("reset_perf_flush", hif.PerfFlushCnt, 32'd0);

        // Forwarding: M beats W, fall back to W, x0 never forwarded.
        tick();
        hif.RdM = 5'd5; hif.RegWriteM = 1'b1; hif.RdW = 5'd5; hif.RegWriteW = 1'b1;
        hif.Rs1E = 5'd5; hif.Rs2E = 5'd5;
        settle();
        check("fwdA_M", 32'(hif.ForwardAE), 32'd2);
        check("fwdB_M", 32'(hif.ForwardBE), 32'd2);
        hif.RdM = 5'd0;
        settle();
        check("fwdA_W", 32'(hif.ForwardAE), 32'd1);
        check("fwdB_W", 32'(hif.ForwardBE), 32'd1);
        hif.Rs2E = 5'd6;
        settle();
        check("fwdB_nomatch", 32'(hif.ForwardBE), 32'd0);
        hif.RegWriteW = 1'b0;
        settle();
        check("fwdA_noWE", 32'(hif.ForwardAE), 32'd0);
        hif.Rs1E = 5'd0; hif.RdW = 5'd0; hif.RegWriteW = 1'b1;
        hif.RdM = 5'd0; hif.RegWriteM = 1'b1;
        settle();
        check("fwdA_x0", 32'(hif.ForwardAE), 32'd0);
        clear_in();

        // Load-use hazard.
        tick();
        hif.LoadE = 1'b1; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
        settle();
        check("lw_stall", ctl(), 32'b110010);
        tick();
        hif.LoadE = 1'b0;
        settle();
        check("lw_released", ctl(), 32'd0);
        hif.LoadE = 1'b1; hif.RdE = 5'd0; hif.Rs2D = 5'd0; hif.Rs1D = 5'd3;
        settle();
        check("lw_x0", ctl(), 32'd0);
        hif.RdE = 5'd3;
        settle();
        check("lw_rs1", ctl(), 32'b110010);

        // Branch flush wins over load-use.
        hif.PCSrcE = 1'b1;
        settle();
        check("branch_over_lw", ctl(), 32'b000110);
        clear_in();

        // M-unit: MdOpE at cycle0, MdDone at cycle4.
        tick();
        hif.MdOpE = 1'b1;
        settle();
        check("md_c0_start", 32'(hif.MdStart), 32'd1);
        check("md_c0_ctl", ctl(), 32'b111001);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 2) begin
                hif.LoadE = 1'b1; hif.RdE = 5'd7; hif.Rs1D = 5'd7;
            end
            settle();
            check($sformatf("md_c%0d_start", c), 32'(hif.MdStart), 32'd0);
            check($sformatf("md_c%0d_ctl", c), ctl(), 32'b111001);
        end
        tick();
        hif.LoadE = 1'b0;
        hif.MdDone = 1'b1;
        settle();
        check("md_c4_ctl", ctl(), 32'd0);
        check("md_c4_start", 32'(hif.MdStart), 32'd0);
        tick();
        hif.MdOpE = 1'b0; hif.MdDone = 1'b0;
        settle();
        check("md_idle_after", all_outs(), 32'd0);

        // Stray MdDone in idle is ignored.
        hif.MdDone = 1'b1;
        settle();
        check("md_stray_done", all_outs(), 32'd0);
        tick();
        hif.MdDone = 1'b0;
        settle();
        check("md_stray_done_next", all_outs(), 32'd0);

        // Watchdog: stall through cycles 0..33, released in cycle 34, then sticky timeout.
        hif.MdOpE = 1'b1;
        settle();
        check("wd_c0_start", 32'(hif.MdStart), 32'd1);
        for (int c = 1; c <= 33; c++) begin
            tick();
            if (c == 1 || c == 33) check($sformatf("wd_c%0d_ctl", c), ctl(), 32'b111001);
        end
        tick();
        check("wd_c34_ctl", ctl(), 32'd0);
        check("wd_c34_to", 32'(hif.MdTimeout), 32'd0);
        tick();
        hif.MdOpE = 1'b0;
        settle();
        check("wd_timeout", 32'(hif.MdTimeout), 32'd1);
        check("wd_idle_ctl", ctl(), 32'd0);
        tick(); tick();
        check("wd_sticky", 32'(hif.MdTimeout), 32'd1);
        hif.MdOpE = 1'b1;
        settle();
        check("wd_restart", 32'(hif.MdStart), 32'd1);
        tick();
        hif.MdDone = 1'b1;
        settle();
        check("wd_restart_done", ctl(), 32'd0);
        check("wd_still_sticky", 32'(hif.MdTimeout), 32'd1);
        tick();
        hif.MdOpE = 1'b0; hif.MdDone = 1'b0;
        reset = 1'b1;
        settle();
        check("wd_reset_clears", 32'(hif.MdTimeout), 32'd0);
        reset = 1'b0;
        settle();

        // Asynchronous reset in the middle of a busy sequence.
        tick();
        hif.MdOpE = 1'b1;
        tick(); tick();
        check("rst_busy_c2", ctl(), 32'b111001);
        reset = 1'b1;
        settle();
        check("rst_busy_drop", ctl(), 32'd0);
        check("rst_busy_nostart", 32'(hif.MdStart), 32'd0);
        hif.MdOpE = 1'b0;
        tick();
        reset = 1'b0;
        settle();
        check("rst_release", all_outs(), 32'd0);
        tick();
        check("rst_no_reissue", 32'(hif.MdStart), 32'd0);
        check("rst_perf_stall0", hif.PerfStallCnt, 32'd0);

        // Two load-use cycles after reset: one stall and one flush per cycle.
        hif.LoadE = 1'b1; hif.RdE = 5'd9; hif.Rs1D = 5'd9;
        tick(); tick();
        clear_in();
        settle();
`ifdef HAZARD_PERF_EN
        exp_perf = 32'd2;
`else
        exp_perf = 32'd0;
`endif
        check("perf_stall", hif.PerfStallCnt, exp_perf);
        check("perf_flush", hif.PerfFlushCnt, exp_perf);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
